// File: rtl/mux_nto1_stream.sv
// N-channel, W-bit streaming selector with a registered valid/ready output stage.
// Grant is manual (sel) or round-robin. Define MUX_PARITY_EN to add the out_par output.
module mux_nto1_stream #(
    parameter int NCH  = 8,
    parameter int W    = 1,
    parameter int SELW = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] in_data,
    input  logic [NCH-1:0]   in_valid,
    output logic [NCH-1:0]   in_ready,
    input  logic             mode,
    input  logic [SELW-1:0]  sel,
    output logic [W-1:0]     out_data,
    output logic [SELW-1:0]  out_ch,
    output logic             out_valid,
`ifdef MUX_PARITY_EN
    output logic             out_par,
`endif
    input  logic             out_ready
);

    logic            valid_q, valid_d;
    logic [W-1:0]    data_q, data_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic [SELW-1:0] last_q, last_d;
    logic            load_en, xfer;

    logic [NCH-1:0]  man_oh, hi_mask, rr_req, rr_oh, gnt_oh, xfer_oh;
    logic [NCH:0][W-1:0]    data_acc;
    logic [NCH:0][SELW-1:0] ch_acc;

    assign load_en = !valid_q || out_ready;

    // Per-channel grant terms and one-hot to data/index reduction chains.
    // An out-of-range sel matches no channel, so it never grants.
    assign data_acc[0] = '0;
    assign ch_acc[0]   = '0;
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign man_oh[g]     = in_valid[g] && (sel == SELW'(g));
        assign hi_mask[g]    = (SELW'(g) > last_q);
        assign data_acc[g+1] = data_acc[g] | (xfer_oh[g] ? in_data[g*W +: W] : '0);
        assign ch_acc[g+1]   = ch_acc[g]   | (xfer_oh[g] ? SELW'(g) : '0);
    end

    // Round-robin: prefer requesters above the last winner, else wrap to the lowest.
    assign rr_req = (|(in_valid & hi_mask)) ? (in_valid & hi_mask) : in_valid;
    assign rr_oh  = rr_req & (~rr_req + NCH'(1));

    assign gnt_oh   = mode ? rr_oh : man_oh;
    assign in_ready = (load_en && rst_n) ? gnt_oh : '0;
    assign xfer_oh  = in_ready & in_valid;
    assign xfer     = |xfer_oh;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        last_d  = last_q;
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = data_acc[NCH];
            ch_d    = ch_acc[NCH];
            last_d  = ch_acc[NCH];
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            last_q  <= SELW'(NCH - 1);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;

`ifdef MUX_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (xfer) par_d = ^data_acc[NCH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end

    assign out_par = par_q;
`endif

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Bench for mux_nto1_stream: per-cycle model compare on an 8x8 instance plus
// directed literal checks, and a 6-channel instance for out-of-range sel.
module tb_mux_nto1_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] in_data  = '0;
  logic [7:0]  in_valid = '0;
  logic [7:0]  in_ready;
  logic        mode = 1'b0;
  logic [2:0]  sel = '0;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic [47:0] b_data  = '0;
  logic [5:0]  b_valid = '0;
  logic [5:0]  b_rdy;
  logic        b_mode = 1'b0;
  logic [2:0]  b_sel = '0;
  logic [7:0]  b_out;
  logic [2:0]  b_ch;
  logic        b_ov;
  logic        b_ordy = 1'b0;
`ifdef MUX_PARITY_EN
  logic out_par, b_par;
`endif

  int errs = 0;
  int checks = 0;

  mux_nto1_stream #(.NCH(8), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid),
`ifdef MUX_PARITY_EN
    .out_par(out_par),
`endif
    .out_ready(out_ready));

  mux_nto1_stream #(.NCH(6), .W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_rdy), .mode(b_mode), .sel(b_sel), .out_data(b_out),
    .out_ch(b_ch), .out_valid(b_ov),
`ifdef MUX_PARITY_EN
    .out_par(b_par),
`endif
    .out_ready(b_ordy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the 8-channel instance: output register contents and rr pointer.
  int         m_last  = 7;
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = '0;
  int         m_ch    = 0;

  function automatic int model_grant();
    if (!mode) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 1; k <= 8; k++)
      if (in_valid[3'((m_last + k) % 8)]) return (m_last + k) % 8;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_data <= '0; m_ch <= 0; m_last <= 7;
    end else if ((!m_valid || out_ready) && model_grant() >= 0) begin
      m_valid <= 1'b1;
      m_data  <= 8'(in_data >> (8 * model_grant()));
      m_ch    <= model_grant();
      m_last  <= model_grant();
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [7:0] er;
    g  = model_grant();
    er = (rst_n && (!m_valid || out_ready) && g >= 0) ? 8'(1 << g) : 8'h00;
    chk("m_in_ready", 32'(in_ready), 32'(er));
    chk("m_out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("m_out_data", 32'(out_data), 32'(m_data));
      chk("m_out_ch", 32'(out_ch), 32'(m_ch));
`ifdef MUX_PARITY_EN
      chk("m_out_par", 32'(out_par), 32'(^m_data));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [7:0] v);
    in_data[i*8 +: 8] = v;
  endtask

  initial begin
    int exp_sp[4];
    exp_sp = '{2, 5, 2, 5};
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;

    // Manual select on both instances
    mode = 1'b0; sel = 3'd3; in_valid = 8'h08; set_ch(3, 8'hA5); out_ready = 1'b1;
    b_mode = 1'b0; b_sel = 3'd1; b_valid = 6'h3F; b_data[8 +: 8] = 8'h77; b_ordy = 1'b1;
    step();
    chk("man_data", 32'(out_data), 32'hA5);
    chk("man_ch", 32'(out_ch), 32'd3);
    chk("man_valid", 32'(out_valid), 32'd1);
`ifdef MUX_PARITY_EN
    chk("par_a5", 32'(out_par), 32'd0);
`endif
    chk("b_valid", 32'(b_ov), 32'd1);
    chk("b_data", 32'(b_out), 32'h77);
    chk("b_ch", 32'(b_ch), 32'd1);
    b_sel = 3'd7;
    #1 chk("b_oob_ready", 32'(b_rdy), 32'd0);
    step();
    chk("b_oob_drain", 32'(b_ov), 32'd0);

    sel = 3'd0; in_valid = 8'h01; set_ch(0, 8'hA4);
    step();
    chk("man_a4", 32'(out_data), 32'hA4);
`ifdef MUX_PARITY_EN
    chk("par_a4", 32'(out_par), 32'd1);
`endif

    rst_n = 1'b0;
    #1 chk("rst_pulse_valid", 32'(out_valid), 32'd0);
    step();
    rst_n = 1'b1;

    // Round-robin, every channel requesting
    for (int i = 0; i < 8; i++) set_ch(i, 8'(8'h10 + i));
    mode = 1'b1; in_valid = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("rr_full_ch", 32'(out_ch), 32'(k % 8));
      chk("rr_full_data", 32'(out_data), 32'(8'h10 + k % 8));
    end

    in_valid = 8'h24;
    #1 chk("rr_sparse_rdy", 32'(in_ready), 32'h04);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_sparse_ch", 32'(out_ch), 32'(exp_sp[k]));
    end

    // Backpressure holds the word and blocks all inputs
    out_ready = 1'b0;
    #1 chk("bp_ready0", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_data", 32'(out_data), 32'h15);
      chk("bp_ch", 32'(out_ch), 32'd5);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_rdy", 32'(in_ready), 32'h04);
    step();
    chk("bp_next_ch", 32'(out_ch), 32'd2);
    chk("bp_next_data", 32'(out_data), 32'h12);

    // Reset in the middle of a stream
    in_valid = 8'hFF;
    step();
    chk("mid_ch", 32'(out_ch), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ch", 32'(out_ch), 32'd0);

    in_valid = 8'h00;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
